// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: ALU control codes, op codes,
// FSM states and the command set understood by the operand/accumulator registers.
package muldiv_sequencer_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b101;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DCMP = 3'd2,
    DSUB = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CMD_HOLD      = 3'd0,
    CMD_LOAD_MUL  = 3'd1,
    CMD_LOAD_DIV  = 3'd2,
    CMD_LOAD_DIV0 = 3'd3,
    CMD_MUL_STEP  = 3'd4,
    CMD_DIV_KEEP  = 3'd5,
    CMD_DIV_SUB   = 3'd6
  } reg_cmd_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response and ALU-steering signals between the core/ALU side and the sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  // Handshake: start is a one-cycle request qualified by !busy; a start seen while
  // busy (or in the done cycle) is dropped. done pulses once with result valid.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  // master = core plus the shared ALU; slave = the sequencer
  modport master (
    output start, op, opa, opb, alu_result,
    input  busy, done, result, alu_srca, alu_srcb, alu_ctrl
  );

  modport slave (
    input  start, op, opa, opb, alu_result,
    output busy, done, result, alu_srca, alu_srcb, alu_ctrl
  );
endinterface

// File: rtl/muldiv_sequencer_regs.sv
// Operand/accumulator registers. acc_hi:acc_lo is the product for multiply and
// rem:quo for divide; mcand holds the multiplicand or the divisor.
module muldiv_regs
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_cmd_t         cmd,
  input  logic             more,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] mcand,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] quo_set;

  always_comb begin
    sum     = acc_lo[0] ? alu_result : acc_hi;
    carry   = acc_lo[0] && (alu_result < acc_hi);
    quo_set = {acc_lo[WIDTH-1:1], 1'b1};
  end

  // Divide keeps the partial remainder pre-shifted: after each bit, the next
  // dividend bit is already in rem[0] when DCMP looks at it. No shift after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      ovf    <= 1'b0;
    end else begin
      case (cmd)
        CMD_LOAD_MUL: begin
          acc_hi <= '0;
          acc_lo <= opa;
          mcand  <= opb;
          ovf    <= 1'b0;
        end
        CMD_LOAD_DIV: begin
          acc_hi <= {{(WIDTH-1){1'b0}}, opa[WIDTH-1]};
          acc_lo <= {opa[WIDTH-2:0], 1'b0};
          mcand  <= opb;
          ovf    <= 1'b0;
        end
        CMD_LOAD_DIV0: begin
          acc_hi <= opa;
          acc_lo <= '1;
          mcand  <= opb;
          ovf    <= 1'b0;
        end
        CMD_MUL_STEP: begin
          acc_hi <= {carry, sum[WIDTH-1:1]};
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        end
        CMD_DIV_KEEP: begin
          if (more) begin
            {ovf, acc_hi} <= {acc_hi, acc_lo[WIDTH-1]};
            acc_lo        <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        CMD_DIV_SUB: begin
          if (more) begin
            {ovf, acc_hi} <= {alu_result, quo_set[WIDTH-1]};
            acc_lo        <= {quo_set[WIDTH-2:0], 1'b0};
          end else begin
            acc_hi <= alu_result;
            acc_lo <= quo_set;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the core ALU
// for every add, subtract and compare step.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus,
  output state_t             dbg_state
);

  state_t           state, state_d;
  reg_cmd_t         cmd;
  logic             more;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load, cnt_dec, res_load, last;
  logic             sel_hi;
  logic [WIDTH-1:0] result_q, result_sel;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic             ovf;
  logic [WIDTH-1:0] srca, srcb;
  logic [2:0]       ctrl;
  logic             busy, done;

  muldiv_regs #(.WIDTH(WIDTH)) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .more       (more),
    .opa        (bus.opa),
    .opb        (bus.opb),
    .alu_result (bus.alu_result),
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .mcand      (mcand),
    .ovf        (ovf)
  );

  assign last       = (cnt == CNT_W'(1));
  // Both MULHU and REMU read the upper register, so op[0] alone picks the result.
  assign result_sel = sel_hi ? acc_hi : acc_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    cmd      = CMD_HOLD;
    more     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    res_load = 1'b0;
    srca     = '0;
    srcb     = '0;
    ctrl     = ALU_ADD;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          cnt_load = 1'b1;
          if (!bus.op[1]) begin
            cmd     = CMD_LOAD_MUL;
            state_d = MUL;
          end else if (bus.opb == '0) begin
            cmd     = CMD_LOAD_DIV0;
            state_d = DONE;
          end else begin
            cmd     = CMD_LOAD_DIV;
            state_d = DCMP;
          end
        end
      end
      MUL: begin
        busy    = 1'b1;
        cmd     = CMD_MUL_STEP;
        cnt_dec = 1'b1;
        if (acc_lo[0]) begin
          srca = acc_hi;
          srcb = mcand;
        end
        if (last) state_d = DONE;
      end
      DCMP: begin
        busy = 1'b1;
        if (ovf) begin
          state_d = DSUB;
        end else begin
          srca = acc_hi;
          srcb = mcand;
          ctrl = ALU_SLTU;
          if (bus.alu_result[0]) begin
            cmd     = CMD_DIV_KEEP;
            more    = !last;
            cnt_dec = 1'b1;
            state_d = last ? DONE : DCMP;
          end else begin
            state_d = DSUB;
          end
        end
      end
      DSUB: begin
        busy    = 1'b1;
        srca    = acc_hi;
        srcb    = mcand;
        ctrl    = ALU_SUB;
        cmd     = CMD_DIV_SUB;
        more    = !last;
        cnt_dec = 1'b1;
        state_d = last ? DONE : DCMP;
      end
      DONE: begin
        done     = 1'b1;
        res_load = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sel_hi   <= 1'b0;
      result_q <= '0;
    end else begin
      if (cnt_load) begin
        cnt    <= CNT_W'(WIDTH);
        sel_hi <= bus.op[0];
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (res_load) result_q <= result_sel;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  // During the done cycle the fresh value bypasses the holding register.
  assign bus.result   = done ? result_sel : result_q;
  assign bus.alu_srca = srca;
  assign bus.alu_srcb = srcb;
  assign bus.alu_ctrl = ctrl;
  assign dbg_state    = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of muldiv_sequencer driving a behavioural 32-bit ALU.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_fail = 0;
  logic   done_d = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] srcb_log[32];
  logic [2:0]   ctrl_log[32];

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus();

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Combinational ALU shared with the core
  always_comb begin
    case (bus.alu_ctrl)
      ALU_ADD:  bus.alu_result = bus.alu_srca + bus.alu_srcb;
      ALU_SUB:  bus.alu_result = bus.alu_srca - bus.alu_srcb;
      ALU_SLTU: bus.alu_result = {{(W-1){1'b0}}, (bus.alu_srca < bus.alu_srcb)};
      default:  bus.alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_d) check("done_pulse", W'(bus.done), '0);
    if (bus.done) check("busy_with_done", W'(bus.busy), '0);
    done_d <= bus.done;
  end

  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      OP_MUL:   return p[W-1:0];
      OP_MULHU: return p[2*W-1:W];
      OP_DIVU:  return (b == '0) ? '1 : a / b;
      default:  return (b == '0) ? a : a % b;
    endcase
  endfunction

  // one DCMP cycle per bit, one extra DSUB for every quotient 1, plus the done cycle
  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a, b);
    if (!op[1]) return W + 1;
    if (b == '0) return 1;
    return W + 1 + $countones(a / b);
  endfunction

  // Waits for done starting from a latency count; lat=1 is the first cycle after accept.
  task automatic wait_done(output logic [W-1:0] res, inout int lat, output bit alu_nz);
    alu_nz = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.alu_srca != '0 || bus.alu_srcb != '0 || bus.alu_ctrl != 3'b000) alu_nz = 1'b1;
      if (lat <= 32) begin
        srcb_log[lat-1] = bus.alu_srcb;
        ctrl_log[lat-1] = bus.alu_ctrl;
      end
      if (bus.done) break;
    end
    res = bus.result;
    check("done_seen", W'(bus.done), W'(1));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, b,
                       output logic [W-1:0] res, output int lat, output bit alu_nz);
    @(negedge clk);
    check("accept_not_busy", W'(bus.busy), '0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    wait_done(res, lat, alu_nz);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
    bit           quiet;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] res;
    int           lat;
    bit           alu_nz;
    int           errs;
    int           n_done;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{OP_MUL,   32'd7,          32'd6,          32'd42,         33, 1'b0};
    vecs[1]  = '{OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, 1'b0};
    vecs[2]  = '{OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,        32'd7,          32'd14,         36, 1'b0};
    vecs[4]  = '{OP_REMU,  32'd100,        32'd7,          32'd2,          36, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          33, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  65, 1'b0};
    vecs[7]  = '{OP_DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b1};
    vecs[8]  = '{OP_REMU,  32'd5,          32'd0,          32'd5,          1,  1'b1};
    vecs[9]  = '{OP_MULHU, 32'h8000_0000,  32'd4,          32'd2,          33, 1'b0};
    vecs[10] = '{OP_REMU,  32'hFFFF_FFFF,  32'h10,         32'hF,          61, 1'b0};
    vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  61, 1'b0};
    vecs[12] = '{OP_MUL,   32'h0,          32'h1234_5678,  32'h0,          33, 1'b0};
    vecs[13] = '{OP_REMU,  32'd6,          32'd7,          32'd6,          33, 1'b0};

    bus.start = 1'b0;
    bus.op    = '0;
    bus.opa   = '0;
    bus.opb   = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy",   W'(bus.busy), '0);
    check("rst_done",   W'(bus.done), '0);
    check("rst_result", bus.result, '0);
    check("rst_srca",   bus.alu_srca, '0);
    check("rst_srcb",   bus.alu_srcb, '0);
    check("rst_ctrl",   W'(bus.alu_ctrl), '0);
    check("rst_state",  W'(dbg_state), W'(IDLE));
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(vecs[i].exp);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, alu_nz);
      check($sformatf("vec%0d_result", i), res, exp_q.pop_front());
      check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
      if (vecs[i].quiet) check($sformatf("vec%0d_alu_quiet", i), W'(alu_nz), '0);
      if (i == 0) begin
        // multiplier 7: only the first three steps add the multiplicand
        errs = 0;
        for (int k = 0; k < 32; k++) begin
          if (srcb_log[k] !== ((k < 3) ? 32'd6 : 32'd0)) errs++;
          if (ctrl_log[k] !== ALU_ADD) errs++;
        end
        check("mul_alu_steer", W'(errs), '0);
      end
    end

    // a second start 10 cycles into a multiply is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.opa = 32'd1000; bus.opb = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_at_ignored_start", W'(bus.busy), W'(1));
    bus.start = 1'b1; bus.op = OP_DIVU; bus.opa = 32'd50; bus.opb = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 10;
    wait_done(res, lat, alu_nz);
    check("ignored_start_result", res, 32'd3000);
    check("ignored_start_latency", W'(lat), 32'd33);

    // start held through the done cycle: dropped there, accepted from IDLE next cycle
    bus.start = 1'b1; bus.op = OP_MULHU; bus.opa = 32'hFFFF_FFFF; bus.opb = 32'd2;
    @(negedge clk);
    check("after_done_busy", W'(bus.busy), '0);
    check("after_done_done", W'(bus.done), '0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    wait_done(res, lat, alu_nz);
    check("b2b_result", res, 32'd1);
    check("b2b_latency", W'(lat), 32'd33);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.opa = 32'hFFFF_FFFF; bus.opb = 32'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_div_busy", W'(bus.busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   W'(bus.busy), '0);
    check("abort_done",   W'(bus.done), '0);
    check("abort_result", bus.result, '0);
    check("abort_state",  W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("no_done_after_abort", W'(n_done), '0);

    // random operations against the reference model
    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 3));
        1:       rb = 32'($urandom_range(0, 65535));
        default: rb = $urandom;
      endcase
      exp_q.push_back(ref_model(rop, ra, rb));
      do_op(rop, ra, rb, res, lat, alu_nz);
      check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), res, exp_q.pop_front());
      check($sformatf("rand%0d_latency", i), W'(lat), W'(ref_lat(rop, ra, rb)));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
